fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 16-entry FIFO between `NREQ` producers. It grants one requester at a time and holds the grant for a bounded burst. It drives the FIFO write request and write data, and returns a per-requester write acknowledge that respects the FIFO full flag. It sits directly in front of the FIFO write-pointer / memory write path.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// DEPTH matches the 16-entry FIFO that sits behind the arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 8;
  localparam int DEPTH     = 16;

endpackage

// File: rtl/rr_pick.sv
// Circular priority picker: first set request at or above rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = fifo_arb_pkg::NREQ,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] sel,
  output logic            valid
);

  logic found;
  int   idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ producers,
// holding each grant for at most MAX_BURST accepted writes.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = fifo_arb_pkg::NREQ,
  parameter int DW        = fifo_arb_pkg::DW,
  parameter int MAX_BURST = fifo_arb_pkg::MAX_BURST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               fifo_full,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               wr,
  output logic [DW-1:0]      wdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   gnt_idx, after_gnt, pick_ptr;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic            any_ack, rel;
  logic [NREQ-1:0] pick_sel;
  logic            pick_valid;

  always_comb begin
    gnt_idx = '0;
    wdata   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PW'(i);
        wdata   = req_data[i*DW +: DW];
      end
    end
  end

  assign wr        = |(gnt & req);
  assign ack       = gnt & req & {NREQ{~fifo_full}};
  assign any_ack   = |ack;
  assign after_gnt = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  assign rel       = (state == BUSY) && (!wr || (any_ack && bcnt == LAST_BEAT));

  // On release the re-pick already sees the advanced pointer, so the
  // handoff happens on the same edge with no idle bubble.
  assign pick_ptr = rel ? after_gnt : rr_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (pick_ptr),
    .sel    (pick_sel),
    .valid  (pick_valid)
  );

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    bcnt_nxt   = bcnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BUSY;
          gnt_nxt   = pick_sel;
          bcnt_nxt  = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          rr_ptr_nxt = after_gnt;
          bcnt_nxt   = '0;
          if (pick_valid) begin
            gnt_nxt = pick_sel;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (any_ack) begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        bcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
      bcnt   <= bcnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random
// traffic, all compared every cycle against an owner/pointer/count model.
module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 8;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_full;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               wr;
  logic [DW-1:0]      wdata;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port (-1 = nobody), pointer, accepted writes.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  fifo_write_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .ack       (ack),
    .wr        (wr),
    .wdata     (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pickFrom(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_ack;
    logic            exp_wr;
    logic [DW-1:0]   exp_wdata;
    exp_gnt   = '0;
    exp_ack   = '0;
    exp_wr    = 1'b0;
    exp_wdata = '0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_wr           = req[m_owner];
      exp_ack[m_owner] = req[m_owner] & ~fifo_full;
      exp_wdata        = req_data[m_owner*DW +: DW];
    end
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("ack", 64'(ack), 64'(exp_ack));
    check("wr", 64'(wr), 64'(exp_wr));
    check("wdata", 64'(wdata), 64'(exp_wdata));
  endtask

  task automatic modelStep();
    int  p;
    bit  acked;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      p = pickFrom(req, m_ptr);
      if (p >= 0) begin
        m_owner = p;
        m_cnt   = 0;
      end
    end else begin
      acked = req[m_owner] && !fifo_full;
      if (!req[m_owner] || (acked && m_cnt == MAX_BURST - 1)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = pickFrom(req, m_ptr);
        m_cnt   = 0;
      end else if (acked) begin
        m_cnt++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic full, input logic rstn);
    @(negedge clk);
    req       = r;
    fifo_full = full;
    rst_n     = rstn;
    req_data  = $urandom;
    #1;
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic full, input logic rstn);
    applyStimulus(r, full, rstn);
    advance();
  endtask

  task automatic doReset();
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Reset state
    doReset();
    applyStimulus('0, 1'b0, 1'b1);
    check("reset_gnt", 64'(gnt), 64'h0);
    check("reset_wr", 64'(wr), 64'h0);
    advance();

    // Single requester: 8 acks then zero-bubble regrant with pointer at 1
    cycle(4'b0001, 1'b0, 1'b1);
    for (int n = 0; n < MAX_BURST; n++) begin
      applyStimulus(4'b0001, 1'b0, 1'b1);
      check("single_ack", 64'(ack), 64'h1);
      advance();
    end
    applyStimulus(4'b0001, 1'b0, 1'b1);
    check("single_regrant", 64'(gnt), 64'h1);
    check("single_rr_ptr", 64'(dut.rr_ptr), 64'h1);
    check("model_ptr_pin", 64'(m_ptr), 64'h1);
    advance();

    // Round-robin fairness over five bursts
    doReset();
    cycle(4'b1111, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      for (int n = 0; n < MAX_BURST; n++) begin
        applyStimulus(4'b1111, 1'b0, 1'b1);
        check("rr_gnt", 64'(gnt), 64'(1 << (g % NREQ)));
        check("rr_wdata", 64'(wdata), 64'(req_data[(g % NREQ)*DW +: DW]));
        advance();
      end
    end

    // Early drop of requester 2 hands off to requester 0 by wrapping
    doReset();
    cycle(4'b0100, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) cycle(4'b0101, 1'b0, 1'b1);
    applyStimulus(4'b0001, 1'b0, 1'b1);
    check("drop_wr", 64'(wr), 64'h0);
    advance();
    applyStimulus(4'b0001, 1'b0, 1'b1);
    check("drop_gnt", 64'(gnt), 64'h1);
    check("drop_bcnt", 64'(dut.bcnt), 64'h0);
    check("drop_rr_ptr", 64'(dut.rr_ptr), 64'h3);
    advance();

    // Full stall mid-burst freezes the count at 4
    doReset();
    cycle(4'b0001, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) cycle(4'b0001, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b0001, 1'b1, 1'b1);
      check("stall_wr", 64'(wr), 64'h1);
      check("stall_ack", 64'(ack), 64'h0);
      check("stall_bcnt", 64'(dut.bcnt), 64'h4);
      advance();
    end
    for (int n = 0; n < 4; n++) begin
      applyStimulus(4'b0001, 1'b0, 1'b1);
      check("resume_bcnt", 64'(dut.bcnt), 64'(4 + n));
      advance();
    end
    applyStimulus(4'b0001, 1'b0, 1'b1);
    check("resume_done_bcnt", 64'(dut.bcnt), 64'h0);
    check("resume_rr_ptr", 64'(dut.rr_ptr), 64'h1);
    advance();

    // Reset mid-burst after the pointer has moved on
    doReset();
    cycle(4'b1111, 1'b0, 1'b1);
    for (int n = 0; n < MAX_BURST + 2; n++) cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    check("midrst_gnt", 64'(gnt), 64'h0);
    check("midrst_wr", 64'(wr), 64'h0);
    check("midrst_ack", 64'(ack), 64'h0);
    advance();
    applyStimulus(4'b1111, 1'b0, 1'b1);
    check("midrst_first_gnt", 64'(gnt), 64'h1);
    advance();

    // Idle return when every request drops together
    cycle(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    check("idle_gnt", 64'(gnt), 64'h0);
    check("idle_wr", 64'(wr), 64'h0);
    advance();

    // Random traffic with occasional full stalls and resets
    for (int n = 0; n < 3000; n++) begin
      cycle(NREQ'($urandom), ($urandom_range(0, 3) == 0),
            !($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
